// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter and its neighbours.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_DBG  = 1'b1;

  // Access width codes, shared with Memory and Control.
  localparam logic [1:0] WIDTH_BYTE = 2'd0;
  localparam logic [1:0] WIDTH_HALF = 2'd1;
  localparam logic [1:0] WIDTH_WORD = 2'd2;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: a lone requester always wins; on a tie the
// port that was not granted last wins.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic valid,
  output logic winner
);

  // Pure combinational selection, no state.
  always_comb begin
    valid  = req0 | req1;
    winner = PORT_CORE;
    if (req0 && req1) begin
      winner = (last == PORT_CORE) ? PORT_DBG : PORT_CORE;
    end else if (req1) begin
      winner = PORT_DBG;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port memory between the core (port 0) and the debug
// loader (port 1). One transaction per grant, requests captured in IDLE.
//   state  | meaning
//   IDLE   | sample requests, memory driven from hold with wren low
//   ACCESS | winner's gnt, memory sees the captured request
//   RESP   | read data returned on rdata with winner's rvalid
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  input  logic [1:0]        c_width,
  input  logic              c_sign,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [1:0]        d_width,
  input  logic              d_sign,
  output logic              c_gnt,
  output logic              d_gnt,
  output logic              c_rvalid,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wren,
  output logic [1:0]        mem_width,
  output logic              mem_sign,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_e        state_q, state_d;
  logic              last_q, last_d;
  logic              win_q, win_d;
  logic              hold_we_q, hold_we_d;
  logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
  logic [DATA_W-1:0] hold_wdata_q, hold_wdata_d;
  logic [1:0]        hold_width_q, hold_width_d;
  logic              hold_sign_q, hold_sign_d;

  logic pick_valid;
  logic pick_win;

  rr_pick2 u_pick (
    .req0   (c_req),
    .req1   (d_req),
    .last   (last_q),
    .valid  (pick_valid),
    .winner (pick_win)
  );

  // State, round-robin pointer and captured request; reset aborts in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_q       <= PORT_DBG;
      win_q        <= PORT_CORE;
      hold_we_q    <= 1'b0;
      hold_addr_q  <= '0;
      hold_wdata_q <= '0;
      hold_width_q <= '0;
      hold_sign_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      win_q        <= win_d;
      hold_we_q    <= hold_we_d;
      hold_addr_q  <= hold_addr_d;
      hold_wdata_q <= hold_wdata_d;
      hold_width_q <= hold_width_d;
      hold_sign_q  <= hold_sign_d;
    end
  end

  // Next state, capture of the winning request, and Moore outputs.
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    win_d        = win_q;
    hold_we_d    = hold_we_q;
    hold_addr_d  = hold_addr_q;
    hold_wdata_d = hold_wdata_q;
    hold_width_d = hold_width_q;
    hold_sign_d  = hold_sign_q;

    c_gnt    = 1'b0;
    d_gnt    = 1'b0;
    c_rvalid = 1'b0;
    d_rvalid = 1'b0;
    rdata    = '0;
    mem_wren = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = ACCESS;
          win_d   = pick_win;
          // Pointer moves at capture; the next pick can only happen in a
          // later IDLE, so this is equivalent to moving it at the grant.
          last_d  = pick_win;
          if (pick_win == PORT_DBG) begin
            hold_we_d    = d_we;
            hold_addr_d  = d_addr;
            hold_wdata_d = d_wdata;
            hold_width_d = d_width;
            hold_sign_d  = d_sign;
          end else begin
            hold_we_d    = c_we;
            hold_addr_d  = c_addr;
            hold_wdata_d = c_wdata;
            hold_width_d = c_width;
            hold_sign_d  = c_sign;
          end
        end
      end
      ACCESS: begin
        c_gnt    = (win_q == PORT_CORE);
        d_gnt    = (win_q == PORT_DBG);
        mem_wren = hold_we_q;
        state_d  = hold_we_q ? IDLE : RESP;
      end
      RESP: begin
        c_rvalid = (win_q == PORT_CORE);
        d_rvalid = (win_q == PORT_DBG);
        rdata    = mem_rdata;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_addr  = hold_addr_q;
  assign mem_wdata = hold_wdata_q;
  assign mem_width = hold_width_q;
  assign mem_sign  = hold_sign_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a 1-cycle-latency memory model.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic c_req = 0, c_we = 0, c_sign = 0, d_req = 0, d_we = 0, d_sign = 0;
  logic [ADDR_W-1:0] c_addr = '0, d_addr = '0;
  logic [DATA_W-1:0] c_wdata = '0, d_wdata = '0;
  logic [1:0] c_width = '0, d_width = '0;
  logic c_gnt, d_gnt, c_rvalid, d_rvalid, mem_wren, mem_sign;
  logic [DATA_W-1:0] rdata, mem_wdata, mem_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [1:0] mem_width;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_width(c_width), .c_sign(c_sign),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_width(d_width), .d_sign(d_sign),
    .c_gnt(c_gnt), .d_gnt(d_gnt), .c_rvalid(c_rvalid), .d_rvalid(d_rvalid),
    .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wren(mem_wren), .mem_width(mem_width), .mem_sign(mem_sign),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: word array, synchronous write, 1-cycle registered read.
  logic [31:0] mem [0:255];
  logic        pl_en = 1'b0;
  logic [7:0]  pl_idx = '0;
  logic [31:0] pl_data = '0;
  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_data;
    else if (mem_wren) mem[mem_addr[9:2]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[9:2]];
  end

  typedef struct {
    logic              port;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [1:0]        width;
    logic              sign;
  } gnt_t;
  typedef struct {
    logic              port;
    logic [DATA_W-1:0] data;
  } rd_t;

  gnt_t exp_g[$];
  rd_t  exp_r[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   wren_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic void push_g(input logic port, input logic we, input logic [ADDR_W-1:0] addr,
                                 input logic [DATA_W-1:0] wdata);
    gnt_t g;
    g.port = port; g.we = we; g.addr = addr; g.wdata = wdata;
    g.width = WIDTH_WORD; g.sign = 1'b0;
    exp_g.push_back(g);
  endfunction

  function automatic void push_r(input logic port, input logic [DATA_W-1:0] data);
    rd_t r;
    r.port = port; r.data = data;
    exp_r.push_back(r);
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: pops the scoreboard whenever the DUT presents a grant or read data.
  initial forever begin
    gnt_t eg;
    rd_t  er;
    @(negedge clk);
    if (mem_wren) wren_cnt++;
    if (c_gnt || d_gnt) begin
      chk("gnt_onehot", c_gnt & d_gnt, 0);
      if (exp_g.size() == 0) begin
        checks++; errors++;
        $display("FAIL gnt_unexpected actual c_gnt=%0b d_gnt=%0b required none", c_gnt, d_gnt);
      end else begin
        eg = exp_g.pop_front();
        chk("gnt_port", d_gnt, eg.port);
        chk("gnt_addr", mem_addr, eg.addr);
        chk("gnt_wren", mem_wren, eg.we);
        if (eg.we) chk("gnt_wdata", mem_wdata, eg.wdata);
        chk("gnt_width", mem_width, eg.width);
        chk("gnt_sign", mem_sign, eg.sign);
      end
    end
    if (c_rvalid || d_rvalid) begin
      chk("rvalid_onehot", c_rvalid & d_rvalid, 0);
      if (exp_r.size() == 0) begin
        checks++; errors++;
        $display("FAIL rvalid_unexpected actual c=%0b d=%0b required none", c_rvalid, d_rvalid);
      end else begin
        er = exp_r.pop_front();
        chk("rvalid_port", d_rvalid, er.port);
        chk("rdata", rdata, er.data);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] idx, input logic [31:0] data);
    pl_idx = idx; pl_data = data; pl_en = 1'b1;
    step(1);
    pl_en = 1'b0;
  endtask

  task automatic set_c(input logic req, input logic we, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] wd);
    c_req = req; c_we = we; c_addr = a; c_wdata = wd; c_width = WIDTH_WORD; c_sign = 1'b0;
  endtask

  task automatic set_d(input logic req, input logic we, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] wd);
    d_req = req; d_we = we; d_addr = a; d_wdata = wd; d_width = WIDTH_WORD; d_sign = 1'b0;
  endtask

  // which: 0 core, 1 debug, 2 either. Returns the cycle number or -1.
  task automatic wait_gnt(input int which, output int at);
    at = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if ((which == 0 && c_gnt) || (which == 1 && d_gnt) || (which == 2 && (c_gnt || d_gnt))) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) chk("gnt_timeout", 1, 0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_flags"}, {c_gnt, d_gnt, c_rvalid, d_rvalid, mem_wren, mem_sign, mem_width}, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_wdata"}, mem_wdata, 0);
    chk({tag, "_rdata"}, rdata, 0);
  endtask

  // One complete transaction on one port: present, wait for gnt, drop req.
  task automatic req_one(input logic port, input logic we, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] wd);
    int at;
    if (port == PORT_DBG) set_d(1'b1, we, a, wd); else set_c(1'b1, we, a, wd);
    wait_gnt(port ? 1 : 0, at);
    step(1);
    if (port == PORT_DBG) d_req = 1'b0; else c_req = 1'b0;
  endtask

  initial begin
    int at, prev, w0;
    logic seen;

    // Reset state while held, then idle with no requests.
    step(2);
    chk_outputs_zero("reset");
    #3 rst = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      seen = seen | mem_wren;
    end
    chk("idle_wren", seen, 0);
    step(1);

    // Single core read with latency checks.
    preload(8'h04, 32'hDEADBEEF);
    push_g(PORT_CORE, 1'b0, 10'h010, 32'h0);
    push_r(PORT_CORE, 32'hDEADBEEF);
    set_c(1'b1, 1'b0, 10'h010, 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("rd_gnt_latency", c_gnt, 1);
    @(posedge clk);
    #1 c_req = 1'b0;
    @(negedge clk);
    chk("rd_rvalid_latency", c_rvalid, 1);
    step(2);

    // Debug write, exactly one wren cycle, then core reads it back.
    w0 = wren_cnt;
    push_g(PORT_DBG, 1'b1, 10'h020, 32'h12345678);
    req_one(PORT_DBG, 1'b1, 10'h020, 32'h12345678);
    step(2);
    chk("wr_wren_cycles", wren_cnt - w0, 1);
    push_g(PORT_CORE, 1'b0, 10'h020, 32'h0);
    push_r(PORT_CORE, 32'h12345678);
    req_one(PORT_CORE, 1'b0, 10'h020, 32'h0);
    step(3);

    // Tie after reset: core first, then strict alternation.
    preload(8'h10, 32'hC0C0C0C0);
    preload(8'h11, 32'hD0D0D0D0);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(1);
    for (int k = 0; k < 4; k++) begin
      push_g(k[0], 1'b0, k[0] ? 10'h044 : 10'h040, 32'h0);
      push_r(k[0], k[0] ? 32'hD0D0D0D0 : 32'hC0C0C0C0);
    end
    set_c(1'b1, 1'b0, 10'h040, 32'h0);
    set_d(1'b1, 1'b0, 10'h044, 32'h0);
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(2, at);
      if (k > 0) chk("alt_spacing", at - prev, 3);
      prev = at;
    end
    step(1);
    c_req = 1'b0;
    d_req = 1'b0;
    step(4);

    // Reset during the ACCESS cycle of a debug write.
    preload(8'h0C, 32'hCAFE0000);
    set_d(1'b1, 1'b1, 10'h030, 32'h55555555);
    @(posedge clk);
    #2;
    chk("abort_wren_before", mem_wren, 1);
    rst = 1'b1;
    #1;
    chk_outputs_zero("abort");
    d_req = 1'b0;
    @(negedge clk);
    chk("abort_no_gnt", d_gnt, 0);
    step(1);
    rst = 1'b0;
    step(3);
    chk("abort_mem_unchanged", mem[12], 32'hCAFE0000);

    // Back-to-back core writes with req held high.
    for (int k = 0; k < 4; k++) push_g(PORT_CORE, 1'b1, 10'h100 + 10'(4 * k), 32'hA0000000 + k);
    set_c(1'b1, 1'b1, 10'h100, 32'hA0000000);
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(0, at);
      if (k > 0) chk("b2b_spacing", at - prev, 2);
      prev = at;
      step(1);
      if (k < 3) set_c(1'b1, 1'b1, 10'h100 + 10'(4 * (k + 1)), 32'hA0000000 + k + 1);
      else c_req = 1'b0;
    end
    step(2);
    push_g(PORT_CORE, 1'b0, 10'h108, 32'h0);
    push_r(PORT_CORE, 32'hA0000002);
    req_one(PORT_CORE, 1'b0, 10'h108, 32'h0);
    step(4);

    chk("sb_gnt_drained", exp_g.size(), 0);
    chk("sb_rd_drained", exp_r.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
